// File: rtl/ring_counter_multi_if.sv
// Control and status bundle for ring_counter_multi: sequencer-side controls in, counter state out.
interface ring_counter_multi_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             up_dnN;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic             err;
  logic             armed;

  modport master (
    output en, up_dnN, mode, load, load_val,
    input  count, wrap, err, armed
  );

  modport slave (
    input  en, up_dnN, mode, load, load_val,
    output count, wrap, err, armed
  );
endinterface

// File: rtl/ring_counter_multi.sv
// Multi-mode up/down sequence counter: one-hot ring, Johnson or binary, with parallel load,
// wrap pulse and self-correction of illegal ring/Johnson states.
module ring_counter_multi #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic                clk,
  input  logic                reset,
  ring_counter_multi_if.slave bus
);
  localparam logic [1:0]       MODE_RING = 2'b00;
  localparam logic [1:0]       MODE_JOHN = 2'b01;
  localparam logic [1:0]       MODE_BIN  = 2'b10;
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);

  logic [WIDTH-1:0] count_q, count_d;
  logic [1:0]       mode_q, mode_d;
  logic             armed_q;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] inc_c, dec_c, inv_c, inv_inc_c, ring_nxt_c, john_nxt_c;
  logic [WIDTH:0]   sum_c, diff_c;
  logic             ring_ok_c, john_ok_c;

  // Seed a sequence restarts from; hold mode keeps whatever is there.
  function automatic logic [WIDTH-1:0] seed_of(input logic [1:0] m, input logic [WIDTH-1:0] cur);
    case (m)
      MODE_RING: seed_of = ONE;
      MODE_JOHN: seed_of = '0;
      MODE_BIN:  seed_of = '0;
      default:   seed_of = cur;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= ONE;
      mode_q  <= MODE_RING;
      armed_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      mode_q  <= mode_d;
      armed_q <= 1'b1;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  // Next-state: arming > load > mode change > enabled advance
  always_comb begin
    count_d    = count_q;
    mode_d     = mode_q;
    wrap_d     = 1'b0;
    err_d      = 1'b0;
    inc_c      = count_q + ONE;
    dec_c      = count_q - ONE;
    inv_c      = ~count_q;
    inv_inc_c  = inv_c + ONE;
    sum_c      = {1'b0, count_q} + {1'b0, STEP_W};
    diff_c     = {1'b0, count_q} - {1'b0, STEP_W};
    // Legal Johnson codes are 0..01..1 (x & (x+1) == 0) or their complements
    ring_ok_c  = (count_q != '0) && ((count_q & dec_c) == '0);
    john_ok_c  = ((count_q & inc_c) == '0) || ((inv_c & inv_inc_c) == '0);
    ring_nxt_c = bus.up_dnN ? {count_q[WIDTH-2:0], count_q[WIDTH-1]}
                            : {count_q[0], count_q[WIDTH-1:1]};
    john_nxt_c = bus.up_dnN ? {count_q[WIDTH-2:0], ~count_q[WIDTH-1]}
                            : {~count_q[0], count_q[WIDTH-1:1]};

    if (!armed_q) begin
      mode_d  = bus.mode;
      count_d = seed_of(bus.mode, count_q);
    end else if (bus.load) begin
      mode_d  = bus.mode;
      count_d = bus.load_val;
    end else if (bus.mode != mode_q) begin
      mode_d  = bus.mode;
      count_d = seed_of(bus.mode, count_q);
    end else if (bus.en) begin
      case (mode_q)
        MODE_RING: begin
          if (!ring_ok_c) begin
            count_d = ONE;
            err_d   = 1'b1;
          end else begin
            count_d = ring_nxt_c;
            wrap_d  = bus.up_dnN ? count_q[WIDTH-1] : count_q[0];
          end
        end
        MODE_JOHN: begin
          if (!john_ok_c) begin
            count_d = '0;
            err_d   = 1'b1;
          end else begin
            count_d = john_nxt_c;
            wrap_d  = (john_nxt_c == '0) && (count_q != '0);
          end
        end
        MODE_BIN: begin
          count_d = bus.up_dnN ? sum_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
          wrap_d  = bus.up_dnN ? sum_c[WIDTH] : diff_c[WIDTH];
        end
        default: ;
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.err   = err_q;
  assign bus.armed = armed_q;
endmodule

// File: tb/tb_ring_counter_multi.sv
// Scoreboard bench for ring_counter_multi: directed sequences plus random traffic against a
// phase/index-based reference model.
module tb_ring_counter_multi;
  localparam int W    = 8;
  localparam int STEP = 3;
  localparam int MOD  = 1 << W;

  typedef struct {
    logic [W-1:0] count;
    logic         wrap;
    logic         err;
    logic         armed;
    int           tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  ring_counter_multi_if #(.WIDTH(W)) bus ();

  ring_counter_multi #(.WIDTH(W), .STEP(STEP)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   ntag   = 0;

  int m_count;
  int m_mode_q;
  bit m_armed;

  // Johnson sequence as a phase 0..2W-1: phase p<=W is p ones from the bottom, beyond that
  // the ones drain out of the bottom.
  function automatic int johnson_val(input int p);
    if (p <= W) return (1 << p) - 1;
    return ((MOD - 1) << (p - W)) & (MOD - 1);
  endfunction

  function automatic int johnson_phase(input int v);
    for (int p = 0; p < 2 * W; p++) if (johnson_val(p) == v) return p;
    return -1;
  endfunction

  function automatic int ring_idx(input int v);
    int n, idx;
    n = 0; idx = -1;
    for (int i = 0; i < W; i++) if (((v >> i) & 1) == 1) begin n++; idx = i; end
    return (n == 1) ? idx : -1;
  endfunction

  function automatic int seed(input int md, input int cur);
    case (md)
      0: return 1;
      1, 2: return 0;
      default: return cur;
    endcase
  endfunction

  task automatic model_reset();
    m_count = 1; m_mode_q = 0; m_armed = 0;
  endtask

  task automatic model_step(input bit e, input bit up, input int md, input bit ld, input int lv,
                            output bit w, output bit er);
    int idx, p, np, n;
    w = 0; er = 0;
    if (!m_armed) begin
      m_armed = 1; m_mode_q = md; m_count = seed(md, m_count);
    end else if (ld) begin
      m_count = lv; m_mode_q = md;
    end else if (md != m_mode_q) begin
      m_mode_q = md; m_count = seed(md, m_count);
    end else if (e && m_mode_q != 3) begin
      case (m_mode_q)
        0: begin
          idx = ring_idx(m_count);
          if (idx < 0) begin m_count = 1; er = 1; end
          else if (up) begin w = (idx == W - 1); m_count = 1 << ((idx + 1) % W); end
          else begin w = (idx == 0); m_count = 1 << ((idx + W - 1) % W); end
        end
        1: begin
          p = johnson_phase(m_count);
          if (p < 0) begin m_count = 0; er = 1; end
          else begin
            np = up ? (p + 1) % (2 * W) : (p + 2 * W - 1) % (2 * W);
            w = (np == 0);
            m_count = johnson_val(np);
          end
        end
        default: begin
          n = up ? m_count + STEP : m_count - STEP;
          w = (n >= MOD) || (n < 0);
          m_count = ((n % MOD) + MOD) % MOD;
        end
      endcase
    end
  endtask

  task automatic push_exp(input bit w, input bit er);
    exp_t x;
    x.count = W'(m_count); x.wrap = w; x.err = er; x.armed = m_armed; x.tag = ntag++;
    sb.push_back(x);
  endtask

  // One clock: drive at negedge, predict the state after the following posedge
  task automatic drive(input bit e, input bit up, input int md, input bit ld, input int lv);
    bit w, er;
    @(negedge clk);
    reset        = 1'b0;
    bus.en       = e;
    bus.up_dnN   = up;
    bus.mode     = 2'(md);
    bus.load     = ld;
    bus.load_val = W'(lv);
    model_step(e, up, md, ld, lv, w, er);
    push_exp(w, er);
  endtask

  // Reset asserted between edges; its effect is expected before the next clock
  task automatic async_reset();
    @(negedge clk);
    #2;
    model_reset();
    push_exp(1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
  endtask

  // Monitor: compare after every clock edge and every reset assertion
  initial begin
    exp_t x;
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        checks++;
        if (bus.count !== x.count || bus.wrap !== x.wrap || bus.err !== x.err ||
            bus.armed !== x.armed) begin
          errors++;
          $display("FAIL chk%0d: got count=%02h wrap=%b err=%b armed=%b, want count=%02h wrap=%b err=%b armed=%b",
                   x.tag, bus.count, bus.wrap, bus.err, bus.armed,
                   x.count, x.wrap, x.err, x.armed);
        end
      end
    end
  end

  initial begin
    int md, lv;
    bus.en = 1'b0; bus.up_dnN = 1'b1; bus.mode = 2'b00; bus.load = 1'b0; bus.load_val = '0;
    model_reset();

    // Ring up through a full rotation, then down and hold
    async_reset();
    for (int i = 0; i < 9; i++) drive(1, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);

    // Johnson full 2W cycle from its seed, then some downward steps
    drive(1, 1, 1, 0, 0);
    for (int i = 0; i < 2 * W; i++) drive(1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 0);

    // Binary step 3 across the top and bottom boundaries
    drive(1, 1, 2, 1, 8'hFE);
    drive(1, 1, 2, 0, 0);
    drive(1, 1, 2, 0, 0);
    drive(1, 0, 2, 0, 0);
    drive(1, 0, 2, 0, 0);

    // Illegal loads corrected on next advance; mode change mid-run restarts at seed
    drive(1, 1, 0, 1, 8'h05);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 1, 1, 8'h5A);
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 3, 0, 0);
    drive(1, 0, 3, 0, 0);

    // Reset mid-count, then load and enable on the same edge
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    async_reset();
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 8'h10);
    drive(1, 1, 0, 0, 0);

    // Random traffic
    md = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 63) == 0) async_reset();
      if ($urandom_range(0, 11) == 0) md = $urandom_range(0, 3);
      lv = $urandom_range(0, MOD - 1);
      if ($urandom_range(0, 1) == 1) lv = (md == 1) ? johnson_val($urandom_range(0, 2 * W - 1))
                                                    : 1 << $urandom_range(0, W - 1);
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, md,
            $urandom_range(0, 15) == 0, lv);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
